// File: rtl/fetch_pkg.sv
// Shared widths, default depth and FSM encoding for the instruction fetch controller.
package fetch_pkg;
   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 32;
   localparam int DEPTH_DEFAULT = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_out_reg.sv
// Output holding register: valid/data/pc of the instruction offered to the consumer.
module fetch_out_reg
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic              accept,
   input  logic [DATA_W-1:0] load_data,
   input  logic [ADDR_W-1:0] load_pc,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] pc
);

   // Flush beats a fresh load; a load beats a plain drain on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         pc    <= load_pc;
      end else if (accept) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Sequential instruction fetch: FSM, PC and accepted-instruction counter feeding a
// valid/ready output register.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
   parameter int                DEPTH    = DEPTH_DEFAULT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              busy,
   output logic [ADDR_W-1:0] inst_count
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] redirect_pc_mod;
   logic              accept;
   logic              load;
   logic              clear;

   assign imem_addr = pc_q;
   assign accept    = inst_valid & inst_ready;

   always_comb begin
      pc_inc          = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + 16'd1;
      redirect_pc_mod = ADDR_W'(32'(redirect_pc) % 32'(DEPTH));
      // Redirect suppresses the fetch of the stale PC at the same edge.
      load  = (state == ST_RUN) && !redirect_valid && !halt && (!inst_valid || inst_ready);
      clear = redirect_valid && (state != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         pc_q       <= RESET_PC;
         inst_count <= '0;
      end else begin
         if (accept && (inst_count != '1))
            inst_count <= inst_count + 16'd1;

         if (redirect_valid)
            pc_q <= redirect_pc_mod;
         else if (load)
            pc_q <= pc_inc;

         case (state)
            ST_IDLE: begin
               if (start && !halt) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               // A redirect empties the output, so there is nothing left to drain.
               if (halt && redirect_valid) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (halt) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!inst_valid || accept || redirect_valid) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   fetch_out_reg u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .clear     (clear),
      .accept    (accept),
      .load_data (imem_rdata),
      .load_pc   (pc_q),
      .valid     (inst_valid),
      .data      (inst_data),
      .pc        (inst_pc)
   );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; instruction memory returns address + 100.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        halt;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [15:0] inst_pc;
   logic        busy;
   logic [15:0] inst_count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = 32'(imem_addr) + 32'd100;

   fetch_controller #(
      .RESET_PC (16'h0000),
      .DEPTH    (256)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .busy           (busy),
      .inst_count     (inst_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] p,
                          input logic [31:0] d, input logic [15:0] cnt, input logic [15:0] addr);
      chk({tag, ".valid"}, 32'(inst_valid), 32'(v));
      if (v) begin
         chk({tag, ".pc"},   32'(inst_pc), 32'(p));
         chk({tag, ".data"}, inst_data,    d);
      end
      chk({tag, ".count"}, 32'(inst_count), 32'(cnt));
      chk({tag, ".addr"},  32'(imem_addr),  32'(addr));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; inst_ready = 1'b0;
      #3;
      chk("rst.valid", 32'(inst_valid), 0);
      chk("rst.data",  inst_data, 0);
      chk("rst.pc",    32'(inst_pc), 0);
      chk("rst.count", 32'(inst_count), 0);
      chk("rst.busy",  32'(busy), 0);
      chk("rst.addr",  32'(imem_addr), 0);
      tick(); tick();
      rst_n = 1'b1;

      // stream from reset PC
      start = 1'b1; inst_ready = 1'b1;
      tick();
      chk("start.busy",  32'(busy), 1);
      chk("start.valid", 32'(inst_valid), 0);
      start = 1'b0;
      tick();
      chk_out("first", 1'b1, 16'd0, 32'd100, 16'd0, 16'd1);
      for (int k = 2; k <= 6; k++) begin
         tick();
         chk_out("stream", 1'b1, 16'(k - 1), 32'(99 + k), 16'(k - 1), 16'(k));
      end

      // stall at inst_pc 5
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall", 1'b1, 16'd5, 32'd105, 16'd5, 16'd6);
      end
      inst_ready = 1'b1;
      tick();
      chk_out("resume", 1'b1, 16'd6, 32'd106, 16'd6, 16'd7);

      // redirect while PC=7
      redirect_valid = 1'b1; redirect_pc = 16'h0040;
      tick();
      chk_out("redir", 1'b0, 16'd0, 32'd0, 16'd7, 16'h0040);
      redirect_valid = 1'b0;
      tick();
      chk_out("redir.next", 1'b1, 16'h0040, 32'd164, 16'd7, 16'h0041);

      // wrap, with an out-of-range redirect target reduced modulo DEPTH
      redirect_valid = 1'b1; redirect_pc = 16'h01FE;
      tick();
      chk_out("wrap.redir", 1'b0, 16'd0, 32'd0, 16'd8, 16'h00FE);
      redirect_valid = 1'b0;
      tick(); chk_out("wrap0", 1'b1, 16'd254, 32'd354, 16'd8,  16'd255);
      tick(); chk_out("wrap1", 1'b1, 16'd255, 32'd355, 16'd9,  16'd0);
      tick(); chk_out("wrap2", 1'b1, 16'd0,   32'd100, 16'd10, 16'd1);
      tick(); chk_out("wrap3", 1'b1, 16'd1,   32'd101, 16'd11, 16'd2);

      // halt during stall -> drain
      inst_ready = 1'b0; halt = 1'b1;
      tick();
      chk("drain.busy", 32'(busy), 1);
      chk_out("drain", 1'b1, 16'd1, 32'd101, 16'd11, 16'd2);
      halt = 1'b0;
      tick();
      chk("drain2.busy", 32'(busy), 1);
      chk_out("drain2", 1'b1, 16'd1, 32'd101, 16'd11, 16'd2);
      inst_ready = 1'b1;
      tick();
      chk("drained.busy", 32'(busy), 0);
      chk_out("drained", 1'b0, 16'd0, 32'd0, 16'd12, 16'd2);
      tick();
      chk("idle.busy", 32'(busy), 0);
      chk_out("idle", 1'b0, 16'd0, 32'd0, 16'd12, 16'd2);

      // restart resumes at next unfetched PC
      start = 1'b1;
      tick();
      chk("restart.busy", 32'(busy), 1);
      start = 1'b0;
      tick();
      chk_out("restart", 1'b1, 16'd2, 32'd102, 16'd12, 16'd3);

      // redirect + halt -> IDLE
      inst_ready = 1'b0; halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0020;
      tick();
      chk("rh.busy", 32'(busy), 0);
      chk_out("rh", 1'b0, 16'd0, 32'd0, 16'd12, 16'h0020);
      redirect_valid = 1'b0; start = 1'b1;
      tick();
      chk("sh.busy", 32'(busy), 0);
      chk_out("sh", 1'b0, 16'd0, 32'd0, 16'd12, 16'h0020);

      // redirect + start in IDLE
      halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0030;
      tick();
      chk("rs.busy", 32'(busy), 1);
      chk_out("rs", 1'b0, 16'd0, 32'd0, 16'd12, 16'h0030);
      redirect_valid = 1'b0; start = 1'b0;
      tick();
      chk_out("rs.fetch", 1'b1, 16'h0030, 32'd148, 16'd12, 16'h0031);
      tick();
      chk_out("rs.stall", 1'b1, 16'h0030, 32'd148, 16'd12, 16'h0031);

      // asynchronous reset mid-stall
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(inst_valid), 0);
      chk("arst.data",  inst_data, 0);
      chk("arst.pc",    32'(inst_pc), 0);
      chk("arst.count", 32'(inst_count), 0);
      chk("arst.busy",  32'(busy), 0);
      chk("arst.addr",  32'(imem_addr), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst.idle", 32'(busy), 0);

      // counter saturation
      start = 1'b1; inst_ready = 1'b1;
      tick();
      chk("sat.busy", 32'(busy), 1);
      start = 1'b0;
      repeat (65535) tick();
      chk("sat.fffe", 32'(inst_count), 32'h0000_FFFE);
      chk("sat.pc0",  32'(inst_pc), 32'd254);
      tick();
      chk("sat.cnt1", 32'(inst_count), 32'h0000_FFFF);
      tick();
      chk("sat.cnt2", 32'(inst_count), 32'h0000_FFFF);
      tick();
      chk("sat.cnt3", 32'(inst_count), 32'h0000_FFFF);
      chk("sat.pc3",  32'(inst_pc), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
